// File: rtl/poly_tone_pkg.sv
// Shared constants and helpers for the polyphonic square-wave generator.
// Periods are full-cycle counts at 100 MHz, indexed by note code (0 = silent).
package poly_tone_pkg;

  localparam logic [1:0] DUTY_50 = 2'd0;
  localparam logic [1:0] DUTY_25 = 2'd1;
  localparam logic [1:0] DUTY_12 = 2'd2;
  localparam logic [1:0] DUTY_75 = 2'd3;

  localparam int unsigned NOTE_PERIOD [8] = '{
    0, 227272, 202470, 382262, 340482, 303398, 286368, 255102
  };

  function automatic int unsigned high_time(input int unsigned p, input logic [1:0] duty);
    int unsigned h;
    h = p >> 1;
    unique case (duty)
      DUTY_50: h = p >> 1;
      DUTY_25: h = p >> 2;
      DUTY_12: h = p >> 3;
      DUTY_75: h = p - (p >> 2);
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: latched settings, period counter and registered wave.
// Settings reload only at a wrap or while idle, so periods are never truncated.
module tone_channel
  import poly_tone_pkg::*;
#(
  parameter int unsigned PERIOD_SHIFT = 0,
  parameter int unsigned CNT_W        = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] note,
  input  logic [1:0] octave,
  input  logic [1:0] duty,
  output logic       wave,
  output logic       period_start
);

  logic             en_q;
  logic [2:0]       note_q;
  logic [1:0]       oct_q;
  logic [1:0]       duty_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] high;
  logic             active;
  logic             kill;
  logic             wrap;
  logic             reload;
  int unsigned      raw;

  always_comb begin
    raw = (NOTE_PERIOD[note_q] >> PERIOD_SHIFT) >> oct_q;
    if (raw < 2) begin
      per  = CNT_W'(2);
      high = CNT_W'(1);
    end else begin
      per  = CNT_W'(raw);
      high = CNT_W'(high_time(raw, duty_q));
    end
  end

  assign active = en_q && (note_q != 3'd0);
  // Dropping en is the only change honoured mid-period.
  assign kill   = active && !en;
  assign wrap   = active && (cnt_q == per - 1'b1);
  assign reload = !active || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      note_q       <= 3'd0;
      oct_q        <= 2'd0;
      duty_q       <= 2'd0;
      cnt_q        <= '0;
      wave         <= 1'b0;
      period_start <= 1'b0;
    end else if (kill) begin
      en_q         <= 1'b0;
      cnt_q        <= '0;
      wave         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (reload) begin
        en_q   <= en;
        note_q <= note;
        oct_q  <= octave;
        duty_q <= duty;
      end
      cnt_q        <= reload ? '0 : cnt_q + 1'b1;
      wave         <= active && (cnt_q < high);
      period_start <= active && (cnt_q == '0);
    end
  end

endmodule

// File: rtl/poly_square_gen.sv
// NUM_CH independent square-wave tone channels, a registered popcount mix and
// a first-order sigma-delta modulator driving a 1-bit speaker pin.
module poly_square_gen
  import poly_tone_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PERIOD_SHIFT = 0,
  parameter int unsigned CNT_W        = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            en,
  input  logic [3*NUM_CH-1:0]          note,
  input  logic [2*NUM_CH-1:0]          octave,
  input  logic [2*NUM_CH-1:0]          duty,
  output logic [NUM_CH-1:0]            wave_out,
  output logic [NUM_CH-1:0]            period_start,
  output logic [$clog2(NUM_CH+1)-1:0]  mix_out,
  output logic                         speak_out
);

  localparam int unsigned MIX_W = $clog2(NUM_CH + 1);

  logic [MIX_W-1:0] pop;
  logic [MIX_W-1:0] acc_q;
  logic [MIX_W:0]   sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_channel #(
      .PERIOD_SHIFT(PERIOD_SHIFT),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en[i]),
      .note        (note[3*i +: 3]),
      .octave      (octave[2*i +: 2]),
      .duty        (duty[2*i +: 2]),
      .wave        (wave_out[i]),
      .period_start(period_start[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + MIX_W'(wave_out[i]);
    end
  end

  // acc stays below NUM_CH, so one extra bit holds acc + mix.
  assign sum = {1'b0, acc_q} + {1'b0, mix_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_out   <= '0;
      acc_q     <= '0;
      speak_out <= 1'b0;
    end else begin
      mix_out <= pop;
      if (sum >= (MIX_W+1)'(NUM_CH)) begin
        speak_out <= 1'b1;
        acc_q     <= MIX_W'(sum - (MIX_W+1)'(NUM_CH));
      end else begin
        speak_out <= 1'b0;
        acc_q     <= MIX_W'(sum);
      end
    end
  end

endmodule

// File: tb/tb_poly_square_gen.sv
// Scoreboard bench: stimulus queues expected periods and point checks,
// a negedge monitor pops and compares them and models mix/sigma-delta.
module tb_poly_square_gen;

  localparam int unsigned NUM_CH = 4;

  logic                clk;
  logic                rst_n;
  logic [NUM_CH-1:0]   en;
  logic [3*NUM_CH-1:0] note;
  logic [2*NUM_CH-1:0] octave;
  logic [2*NUM_CH-1:0] duty;
  logic [NUM_CH-1:0]   wave_out;
  logic [NUM_CH-1:0]   period_start;
  logic [2:0]          mix_out;
  logic                speak_out;

  poly_square_gen #(
    .NUM_CH      (NUM_CH),
    .PERIOD_SHIFT(10),
    .CNT_W       (19)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .note        (note),
    .octave      (octave),
    .duty        (duty),
    .wave_out    (wave_out),
    .period_start(period_start),
    .mix_out     (mix_out),
    .speak_out   (speak_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int len; int high; } prec_t;
  typedef struct { string name; int sel; int exp; int act; } dchk_t;

  prec_t pq[$];
  dchk_t dq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    abort_cnt = 0;

  // ---------------- monitor ----------------
  int          abort_ack = 0;
  bit          trk = 0;
  int          plen, phigh;
  logic [NUM_CH-1:0] pw;
  int          pm, am, em, es;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    dchk_t d;
    prec_t e;
    int    act;
    if (abort_ack != abort_cnt) begin
      abort_ack = abort_cnt;
      trk = 0;
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      case (d.sel)
        0:       act = int'(wave_out);
        1:       act = int'(period_start);
        2:       act = int'(mix_out);
        3:       act = int'(speak_out);
        default: act = d.act;
      endcase
      check(d.name, act, d.exp);
    end
    if (period_start[0]) begin
      check("start_wave_high", int'(wave_out[0]), 1);
      if (trk && pq.size() > 0) begin
        e = pq.pop_front();
        check("period_len", plen, e.len);
        check("period_high", phigh, e.high);
      end
      trk = 1;
      plen = 0;
      phigh = 0;
    end
    if (trk) begin
      plen++;
      phigh += int'(wave_out[0]);
    end
    if (!rst_n) begin
      pw = '0;
      pm = 0;
      am = 0;
    end else begin
      em = $countones(pw);
      check("mix_out", int'(mix_out), em);
      es = (am + pm >= NUM_CH) ? 1 : 0;
      check("speak_out", int'(speak_out), es);
      am = es ? am + pm - NUM_CH : am + pm;
      pm = em;
      pw = wave_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string nm, input int sel, input int exp, input int act);
    dchk_t d;
    d.name = nm; d.sel = sel; d.exp = exp; d.act = act;
    dq.push_back(d);
  endtask

  task automatic push_per(input int len, input int high, input int n);
    prec_t r;
    r.len = len; r.high = high;
    for (int k = 0; k < n; k++) pq.push_back(r);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (pq.size() > 0 && k < 4000) begin
      tick();
      k++;
    end
    push_chk({nm, "_drain"}, 4, 0, pq.size());
    pq.delete();
  endtask

  task automatic set_ch(input int ch, input logic e, input logic [2:0] n,
                        input logic [1:0] o, input logic [1:0] d);
    en[ch]             = e;
    note[3*ch +: 3]    = n;
    octave[2*ch +: 2]  = o;
    duty[2*ch +: 2]    = d;
  endtask

  initial begin
    int k, n_spk, n_mix4;
    rst_n = 1'b0; en = '0; note = '0; octave = '0; duty = '0;
    push_chk("rst_wave", 0, 0, 0);
    push_chk("rst_pstart", 1, 0, 0);
    push_chk("rst_mix", 2, 0, 0);
    push_chk("rst_speak", 3, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // A, 50%: 221 / 110
    tick();
    set_ch(0, 1'b1, 3'd1, 2'd0, 2'd0);
    push_per(221, 110, 3);
    drain("t1");

    // Switch to C mid-period: current A period completes, then 373 / 186
    repeat (48) tick();
    set_ch(0, 1'b1, 3'd3, 2'd0, 2'd0);
    push_per(221, 110, 1);
    push_per(373, 186, 2);
    drain("t3");

    // A, octave 1, 25%: 110 / 27
    set_ch(0, 1'b1, 3'd1, 2'd1, 2'd1);
    push_per(373, 186, 1);
    push_per(110, 27, 2);
    drain("t2");

    // Drop en during the high phase, then re-enable
    set_ch(0, 1'b0, 3'd1, 2'd1, 2'd1);
    abort_cnt++;
    push_chk("kill_still_high", 0, 1, 0);
    tick();
    push_chk("kill_low", 0, 0, 0);
    repeat (5) tick();
    set_ch(0, 1'b1, 3'd1, 2'd1, 2'd1);
    push_chk("reen_idle_wave", 0, 0, 0);
    push_chk("reen_idle_pstart", 1, 0, 0);
    tick();
    push_chk("reen_first_pstart", 1, 0, 0);
    tick();
    push_chk("reen_pstart", 1, 1, 0);
    push_chk("reen_wave", 0, 1, 0);
    push_per(110, 27, 2);
    drain("t4");

    // All four channels aligned on A, 50%
    tick();
    en = '0;
    abort_cnt++;
    repeat (2) tick();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 3'd1, 2'd0, 2'd0);
    push_per(221, 110, 2);
    drain("t5");
    k = 0;
    while (period_start[0] !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    push_chk("aligned_pstart", 1, 4'hF, 0);
    n_spk = 0;
    n_mix4 = 0;
    for (int j = 0; j < 442; j++) begin
      if (j > 0) tick();
      n_spk  += int'(speak_out);
      n_mix4 += (mix_out == 3'd4) ? 1 : 0;
    end
    push_chk("speak_density", 4, 220, n_spk);
    push_chk("mix4_count", 4, 220, n_mix4);

    // Asynchronous reset mid-operation, clear seen before any clock edge
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    abort_cnt++;
    push_chk("async_wave", 0, 0, 0);
    push_chk("async_pstart", 1, 0, 0);
    push_chk("async_mix", 2, 0, 0);
    push_chk("async_speak", 3, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    push_chk("post_rst_wave", 0, 0, 0);
    push_chk("post_rst_pstart", 1, 0, 0);
    tick();
    push_chk("post_rst_idle_wave", 0, 0, 0);
    push_chk("post_rst_idle_pstart", 1, 0, 0);
    tick();
    push_chk("restart_pstart", 1, 4'hF, 0);
    push_chk("restart_wave", 0, 4'hF, 0);
    push_per(221, 110, 1);
    drain("t6");
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_square_gen.md
Name: poly_square_gen

Overview:
Multi-channel successor of the single-tone square wave generator. It has NUM_CH independent tone channels. Each channel has its own note, octave shift, duty cycle and enable.
- Retunes glitch-free: new settings take effect only at a period boundary.
- Produces per-channel waves, a registered mix count, and a 1-bit sigma-delta speaker output.
- Sits between the keypad/sequencer logic and the speaker pin.

Parameters:
NUM_CH, 4, number of tone channels (1..8)
PERIOD_SHIFT, 0, right-shift applied to every table period; nonzero only to shorten simulation
CNT_W, 19, period counter width; must hold the longest period (C = 382262)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel enable
note  input  3*NUM_CH  per-channel note code, channel i at [3i+2:3i]; 0 = silent, 1..7 = A,B,C,D,E,F,G
octave  input  2*NUM_CH  per-channel octave up-shift, 0..3
duty  input  2*NUM_CH  per-channel duty code: 0 = 50%, 1 = 25%, 2 = 12.5%, 3 = 75%
wave_out  output  NUM_CH  per-channel square wave, registered
period_start  output  NUM_CH  one-cycle pulse when a channel begins a new period
mix_out  output  $clog2(NUM_CH+1)  number of channels currently high
speak_out  output  1  sigma-delta modulated mix

Behaviour:
- Reset (async on rst_n low, released synchronously to clk): all counters 0, latched settings 0 (silent), wave_out 0, period_start 0, mix_out 0, speak_out 0, accumulator 0.
- Full-period table at 100 MHz: A 227272, B 202470, C 382262, D 340482, E 303398, F 286368, G 255102.
- Period P = (table >> PERIOD_SHIFT) >> octave.
- High time H:
  - duty 0: P>>1
  - duty 1: P>>2
  - duty 2: P>>3
  - duty 3: P - (P>>2)
  - All values truncate.
- If P < 2 after shifting, force P = 2 and H = 1.
- Per-channel counter cnt runs 0..P-1 using the latched P. At cnt == P-1, cnt wraps to 0 and new settings load.
- Reload rule: on the cycle where cnt wraps, or on any cycle while the channel is idle, the channel samples en, note, octave and duty into its latched registers. A channel is idle when latched note == 0 or latched en == 0.
- Idle channel: cnt held at 0, wave 0. A newly valid note therefore starts its first period on the cycle after it is sampled.
- Mid-period changes to note/octave/duty are ignored until the wrap. No truncated or stretched periods.
- en deassert is the exception: the wave is forced low from the next cycle, and the channel becomes idle at once without waiting for the wrap.
- wave_out[i] registered: wave_out[i] = active_i & (cnt_i < H_i), with one cycle of latency from cnt.
- period_start[i] pulses in the same cycle that wave_out[i] shows the value for cnt == 0, and only for an active channel.
- mix_out = popcount(wave_out), registered. It lags wave_out by one cycle.
- Sigma-delta:
  - s = acc + mix_out.
  - If s >= NUM_CH: speak_out <= 1, acc <= s - NUM_CH.
  - Otherwise: speak_out <= 0, acc <= s.
  - acc is always < NUM_CH. The long-run density of speak_out equals mix_out/NUM_CH.
- Channels are fully independent. Simultaneous wraps on several channels need no arbitration.
- Reset mid-period: immediate return to the reset state. No output glitch beyond the async clear.

Decomposition:
- Package poly_tone_pkg holds:
  - NOTE_PERIOD constant array indexed by note code 1..7
  - duty code localparams
  - helper function high_time(P, duty)
- Sub-module tone_channel holds one channel's counter, setting latches, reload and wave register. The top level instantiates NUM_CH copies with generate, plus the popcount and sigma-delta logic.

Test Plan:
1. Set PERIOD_SHIFT=10, ch0 note=1, octave=0, duty=0, en=1 -> P=221, H=110; wave_out[0] high 110 cycles then low 111; period_start[0] every 221 cycles.
2. Same setup with octave=1, duty=1 -> P=110, H=27; 27 high / 83 low.
3. Change ch0 note from 1 to 3 at cnt=50 -> the current 221-cycle period completes; the next period is 373 (382262>>10); no short pulse.
4. Drop en mid-high -> wave_out[0] low on the next cycle. Re-assert en -> period_start on the second cycle after sampling, wave high from cnt 0.
5. NUM_CH=4, all channels note=1, duty=0, aligned -> mix_out alternates 4/0. speak_out is 1 for every cycle mix_out=4 and 0 for every cycle mix_out=0; long-run density matches mix_out/4.
6. Apply rst_n low pulse mid-operation -> all outputs 0 asynchronously; channels restart idle after release.
